// File: rtl/load_align_unit_if.sv
// Data-bus read channel between the load align unit (master) and memory (slave).
interface load_align_unit_if;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_addr,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_addr,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/load_align_unit.sv
// Memory-stage load sequencer: issues one bus read per load, aligns and extends
// the returned word, and holds the result until the pipeline takes it.
module load_align_unit #(
    parameter logic [7:0] EXE_LB_OP  = 8'b1110_0000,
    parameter logic [7:0] EXE_LH_OP  = 8'b1110_0001,
    parameter logic [7:0] EXE_LW_OP  = 8'b1110_0011,
    parameter logic [7:0] EXE_LBU_OP = 8'b1110_0100,
    parameter logic [7:0] EXE_LHU_OP = 8'b1110_0101
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_en,
    input  logic [7:0]                alucontrolM,
    input  logic [31:0]               addrM,
    input  logic                      flush,
    input  logic                      pipe_ready,
    load_align_unit_if.master         bus,
    output logic                      rdata_valid,
    output logic [31:0]               rdata,
    output logic                      stall,
    output logic                      adel,
    output logic [31:0]               badvaddr
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;

    state_e      state_q, state_d;
    logic        discard_q, discard_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;

    logic is_load;
    logic aligned;
    logic start;

    function automatic logic [31:0] format_load(input logic [7:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (op == EXE_LB_OP)       format_load = {{24{b[7]}}, b};
        else if (op == EXE_LBU_OP) format_load = {24'd0, b};
        else if (op == EXE_LH_OP)  format_load = {{16{h[15]}}, h};
        else if (op == EXE_LHU_OP) format_load = {16'd0, h};
        else                       format_load = word;
    endfunction

    always_comb begin
        is_load = (alucontrolM == EXE_LW_OP)  || (alucontrolM == EXE_LB_OP) ||
                  (alucontrolM == EXE_LBU_OP) || (alucontrolM == EXE_LH_OP) ||
                  (alucontrolM == EXE_LHU_OP);
        if (alucontrolM == EXE_LW_OP)
            aligned = (addrM[1:0] == 2'b00);
        else if ((alucontrolM == EXE_LH_OP) || (alucontrolM == EXE_LHU_OP))
            aligned = ~addrM[0];
        else
            aligned = 1'b1;
    end

    // Gated with resetn so nothing combinational escapes while reset is held.
    assign start    = resetn && (state_q == IDLE) && mem_en && !flush && is_load && aligned;
    assign adel     = resetn && (state_q == IDLE) && mem_en && !flush && is_load && !aligned;
    assign badvaddr = adel ? addrM : '0;

    assign stall         = start || (state_q == ADDR) || (state_q == DATA);
    assign rdata_valid   = (state_q == HOLD);
    assign rdata         = rdata_q;
    assign bus.data_req  = (state_q == ADDR);
    assign bus.data_addr = addr_q;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        op_d      = op_q;
        off_d     = off_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ADDR;
                    discard_d = 1'b0;
                    op_d      = alucontrolM;
                    off_d     = addrM[1:0];
                    addr_d    = {addrM[31:2], 2'b00};
                end
            end
            ADDR: begin
                if (bus.data_addr_ok) begin
                    state_d   = DATA;
                    discard_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                // A killed load still owes the bus its data beat; swallow it here.
                if (bus.data_data_ok) begin
                    discard_d = 1'b0;
                    if (flush || discard_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        rdata_d = format_load(op_q, off_q, bus.data_rdata);
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || pipe_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            op_q      <= '0;
            off_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            op_q      <= op_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: aligned loads, address errors, flush and reset cases.
module tb_load_align_unit;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic [7:0]  alucontrolM;
    logic [31:0] addrM;
    logic        flush;
    logic        pipe_ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        stall;
    logic        adel;
    logic [31:0] badvaddr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    load_align_unit_if bus_if ();

    load_align_unit #(
        .EXE_LB_OP  (OP_LB),
        .EXE_LH_OP  (OP_LH),
        .EXE_LW_OP  (OP_LW),
        .EXE_LBU_OP (OP_LBU),
        .EXE_LHU_OP (OP_LHU)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_en      (mem_en),
        .alucontrolM (alucontrolM),
        .addrM       (addrM),
        .flush       (flush),
        .pipe_ready  (pipe_ready),
        .bus         (bus_if),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .stall       (stall),
        .adel        (adel),
        .badvaddr    (badvaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr);
        mem_en      = 1'b1;
        alucontrolM = op;
        addrM       = addr;
    endtask

    task automatic idle_inputs();
        mem_en      = 1'b0;
        alucontrolM = OP_ADD;
        addrM       = '0;
    endtask

    // Full load with the given addr_ok delay; data_ok arrives one cycle after addr_ok.
    task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input int unsigned aok_delay,
                           input logic [31:0] exp);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        tick();
        issue(op, addr);
        #1;
        check({tag, ".start_stall"}, 32'(stall), 32'd1);
        check({tag, ".start_req"}, 32'(bus_if.data_req), 32'd0);
        tick();
        idle_inputs();
        for (int unsigned i = 0; i < aok_delay; i++) begin
            #1;
            check({tag, ".wait_req"}, 32'(bus_if.data_req), 32'd1);
            check({tag, ".wait_stall"}, 32'(stall), 32'd1);
            check({tag, ".wait_addr"}, bus_if.data_addr, exp_addr);
            tick();
        end
        bus_if.data_addr_ok = 1'b1;
        #1;
        check({tag, ".req"}, 32'(bus_if.data_req), 32'd1);
        check({tag, ".addr"}, bus_if.data_addr, exp_addr);
        tick();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = word;
        #1;
        check({tag, ".data_stall"}, 32'(stall), 32'd1);
        check({tag, ".data_req"}, 32'(bus_if.data_req), 32'd0);
        check({tag, ".data_valid"}, 32'(rdata_valid), 32'd0);
        tick();
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = 32'h5A5A_5A5A;
        pipe_ready          = 1'b1;
        #1;
        check({tag, ".valid"}, 32'(rdata_valid), 32'd1);
        check({tag, ".rdata"}, rdata, exp);
        check({tag, ".hold_stall"}, 32'(stall), 32'd0);
        tick();
        pipe_ready = 1'b0;
        #1;
        check({tag, ".done_valid"}, 32'(rdata_valid), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn              = 1'b0;
        flush               = 1'b0;
        pipe_ready          = 1'b0;
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = '0;
        issue(OP_LW, 32'h0000_0006);
        #2;
        check("rst.adel", 32'(adel), 32'd0);
        check("rst.badvaddr", badvaddr, 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.req", 32'(bus_if.data_req), 32'd0);
        check("rst.addr", bus_if.data_addr, 32'd0);
        check("rst.valid", 32'(rdata_valid), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        idle_inputs();
        tick();
        resetn = 1'b1;

        do_load("lb3",   OP_LB,  32'h1000_0003, 32'h80AA_BBCC, 0, 32'hFFFF_FF80);
        do_load("lhu2",  OP_LHU, 32'h2000_0002, 32'h9ABC_1234, 0, 32'h0000_9ABC);
        do_load("lh2",   OP_LH,  32'h2000_0002, 32'h9ABC_1234, 0, 32'hFFFF_9ABC);
        do_load("lw_d3", OP_LW,  32'h0000_0300, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
        do_load("lbu1",  OP_LBU, 32'h0000_0401, 32'h1234_8756, 0, 32'h0000_0087);
        do_load("lb1",   OP_LB,  32'h0000_0401, 32'h1234_8756, 0, 32'hFFFF_FF87);
        do_load("lh0",   OP_LH,  32'h0000_0500, 32'h0000_8001, 0, 32'hFFFF_8001);
        do_load("lbu2",  OP_LBU, 32'h0000_0502, 32'h00AB_0000, 0, 32'h0000_00AB);

        // Misaligned LW and LH
        tick();
        issue(OP_LW, 32'h0000_0006);
        #1;
        check("adel_lw.adel", 32'(adel), 32'd1);
        check("adel_lw.badvaddr", badvaddr, 32'h0000_0006);
        check("adel_lw.req", 32'(bus_if.data_req), 32'd0);
        check("adel_lw.stall", 32'(stall), 32'd0);
        tick();
        issue(OP_LH, 32'h0000_0101);
        #1;
        check("adel_lh.adel", 32'(adel), 32'd1);
        check("adel_lh.badvaddr", badvaddr, 32'h0000_0101);
        tick();
        idle_inputs();
        #1;
        check("adel_after.req", 32'(bus_if.data_req), 32'd0);
        check("adel_after.adel", 32'(adel), 32'd0);

        // Non-load op at odd address
        issue(OP_ADD, 32'h0000_0003);
        #1;
        check("nonload.stall", 32'(stall), 32'd0);
        check("nonload.adel", 32'(adel), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("nonload.req", 32'(bus_if.data_req), 32'd0);

        // Flush in ADDR without addr_ok
        tick();
        issue(OP_LW, 32'h0000_0700);
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        check("fl_addr.req", 32'(bus_if.data_req), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("fl_addr.req_after", 32'(bus_if.data_req), 32'd0);
        check("fl_addr.stall_after", 32'(stall), 32'd0);

        // Flush in DATA before data_ok; a new load must not start while discarding
        tick();
        issue(OP_LW, 32'h0000_0800);
        tick();
        idle_inputs();
        bus_if.data_addr_ok = 1'b1;
        tick();
        bus_if.data_addr_ok = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_data.stall", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        issue(OP_LW, 32'h0000_0900);
        #1;
        check("fl_data.pend_stall", 32'(stall), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("fl_data.no_restart", 32'(bus_if.data_req), 32'd0);
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'h1111_2222;
        #1;
        check("fl_data.consume_valid", 32'(rdata_valid), 32'd0);
        tick();
        bus_if.data_data_ok = 1'b0;
        #1;
        check("fl_data.valid_after", 32'(rdata_valid), 32'd0);
        check("fl_data.stall_after", 32'(stall), 32'd0);

        // Flush coincident with data_ok
        tick();
        issue(OP_LW, 32'h0000_0A00);
        tick();
        idle_inputs();
        bus_if.data_addr_ok = 1'b1;
        tick();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        flush = 1'b1;
        tick();
        bus_if.data_data_ok = 1'b0;
        flush = 1'b0;
        #1;
        check("fl_dok.valid", 32'(rdata_valid), 32'd0);
        check("fl_dok.stall", 32'(stall), 32'd0);

        // HOLD keeps result stable without pipe_ready, flush then drops it
        tick();
        issue(OP_LHU, 32'h0000_0B02);
        tick();
        idle_inputs();
        bus_if.data_addr_ok = 1'b1;
        tick();
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'hCAFE_0000;
        tick();
        bus_if.data_data_ok = 1'b0;
        tick();
        check("hold.valid", 32'(rdata_valid), 32'd1);
        check("hold.rdata", rdata, 32'h0000_CAFE);
        check("hold.stall", 32'(stall), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("fl_hold.valid", 32'(rdata_valid), 32'd0);

        // Reset asserted while in DATA
        tick();
        issue(OP_LW, 32'h0000_0C04);
        tick();
        idle_inputs();
        bus_if.data_addr_ok = 1'b1;
        tick();
        bus_if.data_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst_data.stall", 32'(stall), 32'd0);
        check("rst_data.req", 32'(bus_if.data_req), 32'd0);
        check("rst_data.addr", bus_if.data_addr, 32'd0);
        check("rst_data.rdata", rdata, 32'd0);
        check("rst_data.valid", 32'(rdata_valid), 32'd0);
        tick();
        resetn = 1'b1;
        bus_if.data_data_ok = 1'b1;
        bus_if.data_rdata   = 32'h7777_8888;
        tick();
        bus_if.data_data_ok = 1'b0;
        #1;
        check("rst_data.ignored_valid", 32'(rdata_valid), 32'd0);
        check("rst_data.ignored_stall", 32'(stall), 32'd0);
        check("rst_data.ignored_rdata", rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
